muldiv_seq: RTL and testbench

//  Multi-cycle RV32M sequencer: runs MUL/MULH/MULHSU/MULHU via a pipelined multiplier and
//  DIV/DIVU/REM/REMU via a 1-bit/cycle restoring divider.

---
 rtl/riscv_pkg.sv | 33 +++
 rtl/muldiv_seq_if.sv | 18 +
 rtl/muldiv_div_step.sv | 20 ++
 rtl/muldiv_seq.sv | 156 +++++++++++++++
 tb/tb_muldiv_seq.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared types for the RV32M multiply/divide sequencer.
package riscv_pkg;

  localparam int MULDIV_DIV_ITERS = 32;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } muldiv_state_e;

  function automatic logic op_is_sdiv(muldiv_op_e op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_is_rem(muldiv_op_e op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Core <-> mul/div unit handshake: the core is master, the unit is slave.
interface muldiv_seq_if
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
);
  logic            start;
  muldiv_op_e      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            stall;
  logic            done;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (output start, op, a, b, input stall, done, result, busy);
  modport slave  (input start, op, a, b, output stall, done, result, busy);
endinterface

// File: rtl/muldiv_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, subtract the divisor if it fits, record the quotient bit.
module muldiv_div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);
  // quo_i doubles as the dividend shift register; its MSB is the next bit in
  logic [XLEN:0] shifted;
  logic          fits;

  assign shifted = {rem_i, quo_i[XLEN-1]};
  assign fits    = (shifted >= {1'b0, divisor_i});
  assign rem_o   = fits ? XLEN'(shifted - {1'b0, divisor_i}) : shifted[XLEN-1:0];
  assign quo_o   = {quo_i[XLEN-2:0], fits};
endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: pipelined multiplier plus 1-bit/cycle divider.
// state   | meaning
// IDLE    | waiting for start; latches op/a/b and resolves div special cases
// MUL     | MUL_PIPE cycles of product pipeline
// DIV     | 32 restoring iterations on operand magnitudes
// FIX     | sign fix-up and quotient/remainder select
// DONE    | done pulse, result valid; start ignored
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int MUL_PIPE = 1
) (
  input logic         clk,
  input logic         reset,
  muldiv_seq_if.slave bus
);
  localparam int CW = 5;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  muldiv_state_e   state_q, state_d;
  muldiv_op_e      op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            q_neg_q, q_neg_d, r_neg_q, r_neg_d;

  logic              sa, sb;
  logic [2*XLEN-1:0] prod, mul_out;
  logic [XLEN-1:0]   mul_res, step_rem, step_quo, q_fix, r_fix;
  logic              in_sdiv;

  // Operands are sign-extended to the full product width so one unsigned
  // multiply covers the s*s, s*u and u*u variants.
  assign sa   = ((op_q == OP_MULH) || (op_q == OP_MULHSU)) & a_q[XLEN-1];
  assign sb   = (op_q == OP_MULH) & b_q[XLEN-1];
  assign prod = {{XLEN{sa}}, a_q} * {{XLEN{sb}}, b_q};

  if (MUL_PIPE > 1) begin : g_pipe
    logic [2*XLEN-1:0] pipe_q [MUL_PIPE-1];
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int i = 0; i < MUL_PIPE-1; i++) pipe_q[i] <= '0;
      end else begin
        pipe_q[0] <= prod;
        for (int i = 1; i < MUL_PIPE-1; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign mul_out = pipe_q[MUL_PIPE-2];
  end else begin : g_nopipe
    assign mul_out = prod;
  end

  assign mul_res = (op_q == OP_MUL) ? mul_out[XLEN-1:0] : mul_out[2*XLEN-1:XLEN];

  muldiv_div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (a_q),
    .divisor_i (b_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign q_fix   = q_neg_q ? -a_q : a_q;
  assign r_fix   = r_neg_q ? -rem_q : rem_q;
  assign in_sdiv = op_is_sdiv(bus.op);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    result_d = result_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          op_d = bus.op;
          a_d  = bus.a;
          b_d  = bus.b;
          if (!bus.op[2]) begin
            state_d = ST_MUL;
            cnt_d   = CW'(MUL_PIPE - 1);
          end else if (bus.b == '0) begin
            state_d  = ST_DONE;
            result_d = op_is_rem(bus.op) ? bus.a : '1;
          end else if (in_sdiv && (bus.a == MIN_NEG) && (bus.b == '1)) begin
            state_d  = ST_DONE;
            result_d = op_is_rem(bus.op) ? '0 : bus.a;
          end else begin
            state_d = ST_DIV;
            cnt_d   = CW'(MULDIV_DIV_ITERS - 1);
            a_d     = (in_sdiv && bus.a[XLEN-1]) ? -bus.a : bus.a;
            b_d     = (in_sdiv && bus.b[XLEN-1]) ? -bus.b : bus.b;
            rem_d   = '0;
            q_neg_d = in_sdiv & (bus.a[XLEN-1] ^ bus.b[XLEN-1]);
            r_neg_d = in_sdiv & bus.a[XLEN-1];
          end
        end
      end
      ST_MUL: begin
        if (cnt_q == '0) begin
          result_d = mul_res;
          state_d  = ST_DONE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_DIV: begin
        rem_d = step_rem;
        a_d   = step_quo;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CW'(1);
      end
      ST_FIX: begin
        result_d = op_is_rem(op_q) ? r_fix : q_fix;
        state_d  = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      op_q     <= OP_MUL;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      result_q <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      result_q <= result_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
    end
  end

  assign bus.done   = (state_q == ST_DONE);
  assign bus.busy   = (state_q != ST_IDLE);
  assign bus.stall  = bus.start & ~bus.done;
  assign bus.result = result_q;
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: expected result and done cycle queued at issue.
module tb_muldiv_seq;
  import riscv_pkg::*;

  localparam int MUL_PIPE = 1;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  muldiv_seq_if #(.XLEN(32)) bus();
  muldiv_seq #(.XLEN(32), .MUL_PIPE(MUL_PIPE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [31:0] res;
    int          due;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   done_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
    longint      sx, sy;
    int          ia, ib;
    logic [63:0] p;
    sx = longint'($signed(a));
    sy = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    p  = '0;
    case (op)
      OP_MUL, OP_MULH: p = 64'(sx * sy);
      OP_MULHSU:       p = 64'(sx * longint'({32'b0, b}));
      OP_MULHU:        p = {32'b0, a} * {32'b0, b};
      OP_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (a == MINV && b == 32'hFFFF_FFFF) ? a : 32'(ia / ib);
      OP_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      OP_REM:  return (b == 0) ? a : (a == MINV && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(ia % ib);
      OP_REMU: return (b == 0) ? a : a % b;
      default: p = '0;
    endcase
    return (op == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat(muldiv_op_e op, logic [31:0] a, logic [31:0] b);
    if (op inside {OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU}) return 1 + MUL_PIPE;
    if (b == 0) return 1;
    if ((op == OP_DIV || op == OP_REM) && a == MINV && b == 32'hFFFF_FFFF) return 1;
    return 34;
  endfunction

  always @(negedge clk) begin
    if (!reset && bus.done) begin
      done_cnt++;
      if (sbq.size() == 0) begin
        chk_eq("spurious_done", 64'(bus.done), 0);
      end else begin
        mon_e = sbq.pop_front();
        chk_eq({mon_e.tag, "_res"}, 64'(bus.result), 64'(mon_e.res));
        chk_eq({mon_e.tag, "_cyc"}, 64'(cyc), 64'(mon_e.due));
      end
    end
  end

  task automatic issue(input string tag, input muldiv_op_e op, input logic [31:0] a,
                       input logic [31:0] b, input int due_off);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    sbq.push_back('{res: model(op, a, b), due: cyc + due_off, tag: tag});
  endtask

  // mess: drop start and scramble operands mid-op; the op must still finish once
  task automatic wait_done(input string tag, input bit mess);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (mess && n == 2) begin
        bus.start = 1'b0;
        bus.a     = ~bus.a;
        bus.b     = bus.b + 32'd3;
      end
    end while (!bus.done && n < 100);
    if (!bus.done) chk_eq({tag, "_timeout"}, 64'(bus.done), 1);
    else           chk_eq({tag, "_stall_done"}, 64'(bus.stall), 0);
  endtask

  task automatic run(input string tag, input muldiv_op_e op, input logic [31:0] a,
                     input logic [31:0] b, input bit mess = 1'b0);
    @(negedge clk);
    issue(tag, op, a, b, lat(op, a, b));
    #1 chk_eq({tag, "_stall0"}, 64'(bus.stall), 1);
    wait_done(tag, mess);
    bus.start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return MINV;
      3:       return 32'($urandom_range(0, 40));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int dc;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.op    = OP_MUL;
    bus.a     = '0;
    bus.b     = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk_eq("rst_busy", 64'(bus.busy), 0);
    chk_eq("rst_done", 64'(bus.done), 0);
    chk_eq("rst_result", 64'(bus.result), 0);
    chk_eq("rst_stall", 64'(bus.stall), 0);

    run("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD);
    run("mulh", OP_MULH, MINV, MINV);
    run("mulhsu", OP_MULHSU, MINV, MINV);
    run("mulhu", OP_MULHU, MINV, MINV);
    run("div_neg", OP_DIV, 32'hFFFF_FFEC, 32'd3);
    run("rem_neg", OP_REM, 32'hFFFF_FFEC, 32'd3);
    run("divu_z", OP_DIVU, 32'd5, 32'd0);
    run("rem_ovf", OP_REM, MINV, 32'hFFFF_FFFF);
    run("div_ovf", OP_DIV, MINV, 32'hFFFF_FFFF);
    run("remu_z", OP_REMU, 32'd77, 32'd0);
    run("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h8000_0001);
    run("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h8000_0001);
    run("mess_div", OP_DIV, 32'd1000, 32'hFFFF_FFF9, 1'b1);
    run("mess_mul", OP_MULHU, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1);

    // back-to-back with start held through the done cycle
    @(negedge clk);
    issue("b2b_div", OP_DIV, 32'hFFFF_FF9C, 32'd7, 34);
    wait_done("b2b_div", 1'b0);
    issue("b2b_mul", OP_MUL, 32'd9, 32'd11, 1 + 1 + MUL_PIPE);
    wait_done("b2b_mul", 1'b0);
    bus.start = 1'b0;

    // reset in the middle of a divide
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_DIVU;
    bus.a     = 32'd100;
    bus.b     = 32'd7;
    repeat (11) @(negedge clk);
    chk_eq("rst_mid_busy_before", 64'(bus.busy), 1);
    dc        = done_cnt;
    reset     = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    chk_eq("rst_mid_busy", 64'(bus.busy), 0);
    chk_eq("rst_mid_result", 64'(bus.result), 0);
    chk_eq("rst_mid_done", 64'(bus.done), 0);
    repeat (40) @(negedge clk);
    chk_eq("rst_mid_no_done", 64'(done_cnt), 64'(dc));
    run("after_rst", OP_REMU, 32'd100, 32'd7);

    for (int i = 0; i < 1500; i++) begin
      run("rnd", muldiv_op_e'(3'($urandom_range(0, 7))), pick(), pick(),
          ($urandom_range(0, 19) == 0));
    end

    repeat (5) @(negedge clk);
    chk_eq("sb_empty", 64'(sbq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
